// File: rtl/mem_forward_history_if.sv
// Bus between the MEM-stage store path and the store-data forwarding unit.
// It carries the pipeline controls, the WB writeback, the MEM store and the forwarding results.
interface mem_forward_history_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  stall;
  logic                  flush;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_write_en;
  logic                  wb_data_mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_data_mem_write;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_fwd_sel;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [CNT_WIDTH-1:0]  fwd_count;

  modport master (
    output stall, flush, wb_addr, wb_data, wb_write_en, wb_data_mem_read,
           mem_addr, mem_data_mem_write, mem_data_in,
    input  mem_fwd_sel, mem_data_out, fwd_count
  );

  modport slave (
    input  stall, flush, wb_addr, wb_data, wb_write_en, wb_data_mem_read,
           mem_addr, mem_data_mem_write, mem_data_in,
    output mem_fwd_sel, mem_data_out, fwd_count
  );
endinterface

// File: rtl/mem_forward_history.sv
// MEM-stage store-data forwarding unit. It resolves a store's rs2 against the current WB
// writeback and a DEPTH-entry history of recent writebacks, and counts forwarding events.
module mem_forward_history #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2,
  parameter bit FWD_ALL_WB = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  reset,
  mem_forward_history_if.slave bus
);

  logic [DEPTH-1:0]      r_valid;
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;

  logic                  w_wb_qual;
  logic                  w_store_chk;
  logic                  w_fwd_sel;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  assign w_wb_qual   = bus.wb_write_en && (bus.wb_addr != '0) &&
                       (FWD_ALL_WB || bus.wb_data_mem_read);
  assign w_store_chk = !reset && bus.mem_data_mem_write && (bus.mem_addr != '0);

  // Scan oldest to newest, then the live WB, so the newest matching producer wins.
  always_comb begin
    w_fwd_sel  = 1'b0;
    w_fwd_data = bus.mem_data_in;
    if (w_store_chk) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (r_valid[i] && (r_addr[i] == bus.mem_addr)) begin
          w_fwd_sel  = 1'b1;
          w_fwd_data = r_data[i];
        end
      end
      if (w_wb_qual && (bus.wb_addr == bus.mem_addr)) begin
        w_fwd_sel  = 1'b1;
        w_fwd_data = bus.wb_data;
      end
    end
  end

  // History ages once per unstalled pipeline slot; bubbles push an invalid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      if (bus.flush) begin
        r_valid <= '0;
      end else if (!bus.stall) begin
        for (int i = DEPTH - 1; i > 0; i--) begin
          r_valid[i] <= r_valid[i-1];
          r_addr[i]  <= r_addr[i-1];
          r_data[i]  <= r_data[i-1];
        end
        r_valid[0] <= w_wb_qual;
        r_addr[0]  <= bus.wb_addr;
        r_data[0]  <= bus.wb_data;
      end
      if (!bus.stall && !bus.flush && w_fwd_sel && (r_count != '1)) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.mem_fwd_sel  = w_fwd_sel;
  assign bus.mem_data_out = w_fwd_data;
  assign bus.fwd_count    = r_count;

endmodule

// File: tb/tb_mem_forward_history.sv
// Bench for mem_forward_history: two builds (all-writeback/16-bit counter/depth 2 and
// load-only/4-bit counter/depth 3) share the stimulus and are checked against a slot-queue model.
module tb_mem_forward_history;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int DEPTH_A = 2;
  localparam int DEPTH_B = 3;
  localparam int CW_A    = 16;
  localparam int CW_B    = 4;

  typedef struct {
    logic          rs, st, fl, wen, wrd;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          mw;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
  } step_t;

  typedef struct {
    bit            q;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_forward_history_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW_A)) ifA ();
  mem_forward_history_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW_B)) ifB ();

  mem_forward_history #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_A),
                        .FWD_ALL_WB(1'b1), .CNT_WIDTH(CW_A))
    dutA (.clk(clk), .reset(rst), .bus(ifA.slave));

  mem_forward_history #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH_B),
                        .FWD_ALL_WB(1'b0), .CNT_WIDTH(CW_B))
    dutB (.clk(clk), .reset(rst), .bus(ifB.slave));

  step_t       cur;
  slot_t       histA[$];
  slot_t       histB[$];
  int unsigned cntExp[2];
  int          errors = 0;
  int          checks = 0;

  function automatic step_t mk(logic rs, logic st, logic fl, logic wen, logic wrd,
                               logic [AW-1:0] wa, logic [DW-1:0] wd,
                               logic mw, logic [AW-1:0] ma, logic [DW-1:0] md);
    step_t s;
    s.rs = rs; s.st = st; s.fl = fl; s.wen = wen; s.wrd = wrd;
    s.wa = wa; s.wd = wd; s.mw = mw; s.ma = ma; s.md = md;
    return s;
  endfunction

  function automatic bit qualNow(int d);
    return (cur.wen === 1'b1) && ((cur.wa != '0) === 1'b1) && (d == 0 || cur.wrd === 1'b1);
  endfunction

  // Reference: a store sees the live WB first, then remembered slots newest-first.
  function automatic void modelFwd(input int d, output logic sel, output logic [DW-1:0] data);
    slot_t h[$];
    sel  = 1'b0;
    data = cur.md;
    if (d == 0) h = histA; else h = histB;
    if (cur.rs === 1'b1 || cur.mw !== 1'b1) return;
    if ((cur.ma != '0) !== 1'b1) return;
    if (qualNow(d) && ((cur.wa == cur.ma) === 1'b1)) begin
      sel  = 1'b1;
      data = cur.wd;
      return;
    end
    for (int k = 0; k < h.size(); k++) begin
      if (h[k].q && ((h[k].addr == cur.ma) === 1'b1)) begin
        sel  = 1'b1;
        data = h[k].data;
        return;
      end
    end
  endfunction

  task automatic applyStimulus(input step_t s);
    cur = s;
    rst = s.rs;
    ifA.stall = s.st; ifA.flush = s.fl; ifA.wb_write_en = s.wen; ifA.wb_data_mem_read = s.wrd;
    ifA.wb_addr = s.wa; ifA.wb_data = s.wd;
    ifA.mem_data_mem_write = s.mw; ifA.mem_addr = s.ma; ifA.mem_data_in = s.md;
    ifB.stall = s.st; ifB.flush = s.fl; ifB.wb_write_en = s.wen; ifB.wb_data_mem_read = s.wrd;
    ifB.wb_addr = s.wa; ifB.wb_data = s.wd;
    ifB.mem_data_mem_write = s.mw; ifB.mem_addr = s.ma; ifB.mem_data_in = s.md;
  endtask

  task automatic sampleDut(input int d, output logic s, output logic [DW-1:0] v,
                           output logic [31:0] c);
    if (d == 0) begin
      s = ifA.mem_fwd_sel; v = ifA.mem_data_out; c = 32'(ifA.fwd_count);
    end else begin
      s = ifB.mem_fwd_sel; v = ifB.mem_data_out; c = 32'(ifB.fwd_count);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied, then clock the DUTs.
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      logic          s;
      logic [DW-1:0] v;
      slot_t         e;
      int unsigned   cmax;
      cmax = (d == 0) ? 32'hFFFF : 32'hF;
      modelFwd(d, s, v);
      if (cur.rs === 1'b1) begin
        if (d == 0) histA.delete(); else histB.delete();
        cntExp[d] = 0;
      end else begin
        if (cur.st !== 1'b1 && cur.fl !== 1'b1 && s && cntExp[d] != cmax) cntExp[d]++;
        if (cur.fl === 1'b1) begin
          if (d == 0) histA.delete(); else histB.delete();
        end else if (cur.st !== 1'b1) begin
          e.q = qualNow(d); e.addr = cur.wa; e.data = cur.wd;
          if (d == 0) begin
            histA.push_front(e);
            if (histA.size() > DEPTH_A) void'(histA.pop_back());
          end else begin
            histB.push_front(e);
            if (histB.size() > DEPTH_B) void'(histB.pop_back());
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 1, 1, 5, 32'h1234, 1, 5, 32'hCAFE));
    s.push_back(mk(1, 0, 0, 1, 1, 5, 32'h1234, 1, 5, 32'hCAFE));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hBEEF));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL reset sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL reset data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL reset count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 1) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b0 || ifA.fwd_count !== 16'd0) begin
          errors++; $display("[TB] FAIL reset_hold got sel=%b cnt=%0d want sel=0 cnt=0", ifA.mem_fwd_sel, ifA.fwd_count);
        end
      end
      tick();
    end
  endtask

  task automatic test_same_cycle();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 1, 5, 32'h0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL same_cycle sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL same_cycle data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL same_cycle count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 1) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b1 || ifA.mem_data_out !== 32'hDEADBEEF) begin
          errors++; $display("[TB] FAIL same_cycle_const got sel=%b data=%h want sel=1 data=deadbeef", ifA.mem_fwd_sel, ifA.mem_data_out);
        end
      end
      if (i == 2) begin
        checks++;
        if (ifA.fwd_count !== 16'd1) begin errors++; $display("[TB] FAIL count_step got %0d want 1", ifA.fwd_count); end
      end
      tick();
    end
  endtask

  task automatic test_history_age();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 7, 32'h11111111, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h0));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 7, 32'h11111111, 0, 0, 0));
    for (int b = 0; b < 3; b++) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL age sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL age data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL age count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 3) begin
        checks++;
        if (ifA.mem_data_out !== 32'h11111111) begin errors++; $display("[TB] FAIL age_hit got %h want 11111111", ifA.mem_data_out); end
      end
      if (i == 9) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b0 || ifA.mem_data_out !== 32'h0) begin
          errors++; $display("[TB] FAIL age_expired got sel=%b data=%h want sel=0 data=0", ifA.mem_fwd_sel, ifA.mem_data_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_newest_wins();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 0, 3, 32'hA, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 0, 3, 32'hB, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL newest sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL newest data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL newest count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 3) begin
        checks++;
        if (ifA.mem_data_out !== 32'hB) begin errors++; $display("[TB] FAIL newest_const got %h want b", ifA.mem_data_out); end
      end
      tick();
    end
  endtask

  task automatic test_load_only();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 0, 9, 32'h55, 1, 9, 32'h1));
    s.push_back(mk(0, 0, 0, 1, 1, 9, 32'h66, 1, 9, 32'h1));
    s.push_back(mk(0, 0, 0, 1, 1, 0, 32'h77, 1, 0, 32'h1));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL load_only sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL load_only data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL load_only count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 1) begin
        checks++;
        if (ifB.mem_fwd_sel !== 1'b0 || ifA.mem_fwd_sel !== 1'b1) begin
          errors++; $display("[TB] FAIL alu_wb got A=%b B=%b want A=1 B=0", ifA.mem_fwd_sel, ifB.mem_fwd_sel);
        end
      end
      if (i == 2) begin
        checks++;
        if (ifB.mem_fwd_sel !== 1'b1 || ifB.mem_data_out !== 32'h66) begin
          errors++; $display("[TB] FAIL load_wb got sel=%b data=%h want sel=1 data=66", ifB.mem_fwd_sel, ifB.mem_data_out);
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b0 || ifB.mem_fwd_sel !== 1'b0) begin
          errors++; $display("[TB] FAIL x0_store step%0d got A=%b B=%b want 0 0", i, ifA.mem_fwd_sel, ifB.mem_fwd_sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_flush();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 4, 32'h99, 0, 0, 0));
    for (int k = 0; k < 3; k++) s.push_back(mk(0, 1, 0, 1, 1, 4, 32'h123, 0, 0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 4, 32'h0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h0));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 1, 1, 4, 32'h99, 0, 0, 0));
    s.push_back(mk(0, 0, 1, 1, 1, 4, 32'h55, 1, 4, 32'h0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hAB));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL stall_flush sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL stall_flush data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL stall_flush count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 6) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b1 || ifA.mem_data_out !== 32'h99) begin
          errors++; $display("[TB] FAIL after_stall got sel=%b data=%h want sel=1 data=99", ifA.mem_fwd_sel, ifA.mem_data_out);
        end
      end
      if (i == 7) begin
        checks++;
        if (ifA.fwd_count !== 16'd1) begin errors++; $display("[TB] FAIL stall_count got %0d want 1", ifA.fwd_count); end
      end
      if (i == 9) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b1 || ifA.mem_data_out !== 32'h55) begin
          errors++; $display("[TB] FAIL flush_live_wb got sel=%b data=%h want sel=1 data=55", ifA.mem_fwd_sel, ifA.mem_data_out);
        end
      end
      if (i == 10) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b0 || ifA.mem_data_out !== 32'hAB || ifA.fwd_count !== 16'd0) begin
          errors++; $display("[TB] FAIL after_flush got sel=%b data=%h cnt=%0d want sel=0 data=ab cnt=0", ifA.mem_fwd_sel, ifA.mem_data_out, ifA.fwd_count);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    step_t s[$];
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++) s.push_back(mk(0, 0, 0, 1, 1, 5, DW'(k), 1, 5, 32'h0));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 0, 0, 1, 1, 5, 32'h77, 1, 5, 32'h3));
    s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h4));
    foreach (s[i]) begin
      applyStimulus(s[i]);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL saturate sel step%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL saturate data step%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL saturate count step%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      if (i == 21) begin
        checks++;
        if (ifB.fwd_count !== 4'hF || ifA.fwd_count !== 16'd20) begin
          errors++; $display("[TB] FAIL sat_const got B=%0d A=%0d want B=15 A=20", ifB.fwd_count, ifA.fwd_count);
        end
      end
      if (i == 22) begin
        checks++;
        if (ifA.mem_fwd_sel !== 1'b0 || ifA.mem_data_out !== 32'h3) begin
          errors++; $display("[TB] FAIL sel_in_reset got sel=%b data=%h want sel=0 data=3", ifA.mem_fwd_sel, ifA.mem_data_out);
        end
      end
      if (i == 23) begin
        checks++;
        if (ifB.fwd_count !== 4'h0 || ifA.mem_fwd_sel !== 1'b0) begin
          errors++; $display("[TB] FAIL post_reset got cnt=%0d sel=%b want cnt=0 sel=0", ifB.fwd_count, ifA.mem_fwd_sel);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    step_t s;
    s = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i > 0) begin
        s.rs  = ($urandom_range(0, 79) == 0);
        s.st  = ($urandom_range(0, 9) == 0);
        s.fl  = ($urandom_range(0, 24) == 0);
        s.wen = ($urandom_range(0, 3) != 0);
        s.wrd = $urandom_range(0, 1) == 1;
        s.wa  = AW'($urandom_range(0, 3));
        s.wd  = $urandom;
        s.mw  = ($urandom_range(0, 9) < 7);
        s.ma  = AW'($urandom_range(0, 3));
        s.md  = $urandom;
      end
      applyStimulus(s);
      #1;
      for (int d = 0; d < 2; d++) begin
        logic es, as; logic [DW-1:0] ed, ad; logic [31:0] ac;
        modelFwd(d, es, ed); sampleDut(d, as, ad, ac);
        checks += 3;
        if (as !== es) begin errors++; $display("[TB] FAIL random sel cyc%0d dut%0d got %b want %b", i, d, as, es); end
        if (ad !== ed) begin errors++; $display("[TB] FAIL random data cyc%0d dut%0d got %h want %h", i, d, ad, ed); end
        if (ac !== 32'(cntExp[d])) begin errors++; $display("[TB] FAIL random count cyc%0d dut%0d got %0d want %0d", i, d, ac, cntExp[d]); end
      end
      tick();
    end
  endtask

  initial begin
    cntExp[0] = 0;
    cntExp[1] = 0;
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    $display("[TB] start");
    test_reset();
    test_same_cycle();
    test_history_age();
    test_newest_wins();
    test_load_only();
    test_stall_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_forward_history.md
# mem_forward_history

Parametrised store-data forwarding unit for the MEM stage of the RV32IM pipeline. It resolves the source register of a store (MEM stage) against the current WB-stage writeback and a DEPTH-entry history of recent writebacks, so stores see correct data even when the producing instruction has already left WB. It sits between the EX/MEM pipeline register and the data-memory write port, and replaces the single-entry, load-only MEM forwarding check.

## Interface

- DATA_WIDTH, 32, width of register/store data
- ADDR_WIDTH, 5, register-address width
- DEPTH, 2, number of retired-writeback history entries (1..8)
- FWD_ALL_WB, 1, 1: forward every register writeback; 0: forward only load (data-memory read) writebacks
- CNT_WIDTH, 16, width of forwarding-event counter

- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- STALL  in  1  pipeline stall; history and counter hold
- FLUSH  in  1  invalidate all history entries on next edge
- WB_ADDR  in  ADDR_WIDTH  WB-stage destination register
- WB_DATA  in  DATA_WIDTH  WB-stage writeback value
- WB_WRITE_EN  in  1  WB-stage register write enable
- WB_DATA_MEM_READ  in  1  WB-stage instruction is a load
- MEM_ADDR  in  ADDR_WIDTH  store source register (rs2) in MEM stage
- MEM_DATA_MEM_WRITE  in  1  MEM-stage instruction is a store
- MEM_DATA_IN  in  DATA_WIDTH  store data from EX/MEM register
- MEM_FWD_SEL  out  1  store data is being forwarded
- MEM_DATA_OUT  out  DATA_WIDTH  store data to data memory
- FWD_COUNT  out  CNT_WIDTH  saturating count of forwarding events

## Operation

- Qualifying writeback: WB_WRITE_EN=1, WB_ADDR≠0, and (FWD_ALL_WB=1 or WB_DATA_MEM_READ=1).
- History: DEPTH entries {valid, addr, data}; entry 0 newest.
- On edge with RESET=0, FLUSH=0, STALL=0, qualifying writeback: shift history down one, entry 0 ← {1, WB_ADDR, WB_DATA}, oldest dropped.
- Non-qualifying writeback with STALL=0: history shifts, entry 0 ← invalid (entries age by pipeline slot, not by write).
- STALL=1: history and FWD_COUNT hold.
- FLUSH=1 (RESET=0): all valid bits cleared, regardless of STALL; FWD_COUNT holds.
- Match (combinational) only when MEM_DATA_MEM_WRITE=1 and MEM_ADDR≠0. Priority: current qualifying WB (WB_ADDR==MEM_ADDR) > entry 0 > entry 1 > … > entry DEPTH-1. First match supplies MEM_DATA_OUT, MEM_FWD_SEL=1.
- No match: MEM_FWD_SEL=0, MEM_DATA_OUT=MEM_DATA_IN.
- Register x0 never forwarded; writes to x0 never enter history.
- FWD_COUNT increments by 1 on an edge where MEM_FWD_SEL=1 and STALL=0; saturates at all-ones.
- Address compare is exact equality on ADDR_WIDTH bits; X/Z on addresses is not a match.

## Timing

- Forwarding path is combinational: MEM_FWD_SEL/MEM_DATA_OUT valid in same cycle as MEM/WB inputs; zero latency.
- Writeback enters history one cycle after it is in WB; visible to a store up to DEPTH cycles after leaving WB.
- RESET=1 at an edge: all valid bits 0, FWD_COUNT=0. While RESET is high, MEM_FWD_SEL=0 and MEM_DATA_OUT=MEM_DATA_IN.
- Reset mid-operation discards all history; first cycle after reset forwards only from current WB.
- Simultaneous FLUSH and qualifying WB: history cleared, the WB entry is not captured; current-WB combinational forwarding in that cycle still applies.
- Simultaneous STALL and qualifying WB: not captured (WB instruction re-presented next cycle).
- Same register in several entries: newest wins.

## Test plan

- Load x5=0xDEADBEEF in WB, store rs2=x5 in MEM same cycle -> MEM_FWD_SEL=1, MEM_DATA_OUT=0xDEADBEEF, FWD_COUNT 0→1.
- Load x7=0x11111111 in WB, one bubble, store rs2=x7 with MEM_DATA_IN=0x0 (DEPTH=2) -> forwards 0x11111111; after three bubbles -> SEL=0, data 0x0.
- Writes x3=0xA then x3=0xB on consecutive cycles, store rs2=x3 next cycle -> MEM_DATA_OUT=0xB (newest wins).
- FWD_ALL_WB=0, ALU writeback x9=0x55, store rs2=x9 -> SEL=0; same with WB_DATA_MEM_READ=1 -> SEL=1; write to x0 with store rs2=x0 -> SEL=0.
- Capture x4=0x99, assert STALL 3 cycles, then store rs2=x4 -> still forwards 0x99; FLUSH one cycle instead -> SEL=0.
- Preload FWD_COUNT to all-ones (CNT_WIDTH=4 build, 16 forwards) -> holds 0xF; assert RESET mid-sequence -> count 0, all entries invalid, SEL=0 during reset.
